pwm_core: RTL
=============

// Module: pwm_core
// PURPOSE
//  PWM generator downstream of the register interface. Consumes the 32-bit CTRL word, drives one PWM pin and returns a 32-bit STATUS word to the interface's status_in.
//  Period, duty and polarity go into shadow registers. Shadows update only on a period boundary, so a glitch-free update is guaranteed.
// PARAMETERS
//  DATA_WIDTH  32  width of ctrl/status words (must be >= 2*CNT_WIDTH+8)
//  CNT_WIDTH   12  period/duty counter width
// PORTS
//  clk          in   1           system clock, all logic on posedge
//  reset_n      in   1           asynchronous, active-low reset
//  ctrl         in   DATA_WIDTH  live CTRL word from the register interface
//  status       out  DATA_WIDTH  STATUS word, wired to register interface status_in
//  pwm_out      out  1           registered PWM output
//  period_tick  out  1           1-cycle pulse on every counter wrap while running
// BEHAVIOUR
//  CTRL fields:
//   [0]=EN; [1]=POL (1 inverts output); [7:4]=PRESC; [19:8]=DUTY; [31:20]=PERIOD. Bits [3:2] are ignored.
//  STATUS fields:
//   [0]=ACTIVE (state!=IDLE); [1]=pwm_out; [2]=UPD_PEND; [3]=STOPPING.
//   [27:16]=current cnt; all other bits are 0.
//  Reset values: state=IDLE; cnt, presc_cnt and shadows = 0; pwm_out=0; period_tick=0; status=0.
//  Prescaler: tick asserts for 1 clk every (PRESC_sh+1) clks. presc_cnt counts 0..PRESC_sh, then wraps.
//  Counter: on tick, cnt counts 0..PERIOD_sh, then wraps to 0. The wrap edge is called wrap.
//   On wrap, period_tick=1 in the following cycle.
//  Compare: raw = (cnt < DUTY_sh), unsigned CNT_WIDTH compare.
//   DUTY=0 gives constant 0.
//   DUTY>PERIOD gives constant 1.
//   PERIOD=0: cnt stays 0; output is 1 iff DUTY!=0.
//  Output: pwm_out <= (state!=IDLE) ? raw^POL_sh : POL (live ctrl bit).
//   pwm_out lags cnt by one clk.
//  FSM states:
//   IDLE:
//    EN=1 -> RUN. On that same edge: shadows<=ctrl fields; cnt<=0; presc_cnt<=0.
//    First active pwm_out appears on the next edge.
//   RUN:
//    EN=0 -> STOPPING.
//    On wrap: shadows<=ctrl fields, so new DUTY/PERIOD/PRESC/POL take effect at cnt=0.
//   STOPPING:
//    The current period completes with the old shadows.
//    On wrap -> IDLE, with cnt=0. Shadows are not reloaded.
//    EN=1 before the wrap -> back to RUN, with no break in the waveform.
//  UPD_PEND=1 while ACTIVE and any ctrl field (POL, PRESC, DUTY, PERIOD) differs from its shadow. It clears on the wrap that loads the shadows.
//  Simultaneous events:
//   EN falls on the same edge as wrap in RUN: shadows reload, then state -> STOPPING.
//   Shadow-reload has priority over the stop check.
//  ctrl is static except during register writes (synchronous to clk); no CDC.
//  Reset assertion mid-period: immediate return to reset values, pwm_out=0, no period completion.
// STRUCTURE
//  pwm_defs.vh:
//   field offsets/widths for CTRL and STATUS (EN_BIT, POL_BIT, PRESC_LSB, DUTY_LSB, PERIOD_LSB, ...).
//   FSM encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_STOP=2'd2.
//   Shared with the register interface and the testbench.
//  Sub-module pwm_prescaler (clk, reset_n, clr, div[3:0], tick):
//   presc_cnt with synchronous clear on start/wrap-load.
//  Remainder stays in pwm_core: FSM, shadows, counter, compare, status packing.
// TESTING
//  T1: PERIOD=9, DUTY=3, PRESC=0, EN=1 -> pwm_out high 3 clks / low 7 clks, repeating. period_tick every 10 clks. STATUS[0]=1.
//  T2: as T1, then write DUTY=7 at cnt=5 -> UPD_PEND=1. Current period keeps 3-high. UPD_PEND clears at wrap. Next period is 7 high / 3 low.
//  T3: DUTY=0 -> pwm_out constant 0. DUTY=12 with PERIOD=9 -> constant 1. PERIOD=0, DUTY=1 -> constant 1, with period_tick on every tick.
//  T4: PERIOD=4, DUTY=2, PRESC=1 -> period=10 clks, high 4 clks. PRESC=3 -> period=20 clks.
//  T5: EN=0 at cnt=2 of PERIOD=9 -> STATUS[3]=1 until wrap. Period finishes normally, then IDLE with pwm_out=POL.
//      EN re-raised at cnt=6 -> stays RUN, no gap.
//  T6: POL=1 with T1 settings -> inverted waveform; idle level 1. Assert reset_n=0 at cnt=5 -> pwm_out=0, status=0 immediately.

Source files
------------

// File: rtl/pwm_core_pkg.sv
// ---------------------------------------------------------------------------
// pwm_core_pkg
//   Shared definitions for the PWM block: CTRL / STATUS field positions and
//   the FSM state encoding. Also imported by the register interface and the
//   testbench so that all three agree on the word layout.
//
//   CTRL   : [0] EN, [1] POL, [7:4] PRESC, [DUTY_LSB +: CNT_WIDTH] DUTY,
//            [DUTY_LSB+CNT_WIDTH +: CNT_WIDTH] PERIOD (bits 3:2 ignored)
//   STATUS : [0] ACTIVE, [1] pwm_out, [2] UPD_PEND, [3] STOPPING,
//            [ST_CNT_LSB +: CNT_WIDTH] current counter value
// ---------------------------------------------------------------------------
package pwm_core_pkg;

    // CTRL word layout
    localparam int EN_BIT    = 0;
    localparam int POL_BIT   = 1;
    localparam int PRESC_LSB = 4;
    localparam int PRESC_W   = 4;
    localparam int DUTY_LSB  = 8;

    // STATUS word layout
    localparam int ST_ACTIVE_BIT = 0;
    localparam int ST_PWM_BIT    = 1;
    localparam int ST_UPD_BIT    = 2;
    localparam int ST_STOP_BIT   = 3;
    localparam int ST_CNT_LSB    = 16;

    // FSM encoding; the state is observable through STATUS:
    // IDLE = !ACTIVE, STOP = STOPPING, RUN = ACTIVE & !STOPPING.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } pwm_state_e;

    // PERIOD sits directly above DUTY, so its offset depends on counter width.
    function automatic int period_lsb(input int cnt_width);
        return DUTY_LSB + cnt_width;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// ---------------------------------------------------------------------------
// pwm_prescaler
//   Clock divider for the PWM counter. presc_cnt counts 0..div and wraps;
//   tick is high for the one clock in which presc_cnt == div, i.e. once every
//   (div+1) clocks.
//
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   clr      in   synchronous clear of presc_cnt (idle, start, shadow load)
//   div      in   divide value (shadowed PRESC)
//   tick     out  counter advance enable
// ---------------------------------------------------------------------------
module pwm_prescaler (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic [3:0] div,
    output logic       tick
);

    logic [3:0] presc_cnt;

    assign tick = (presc_cnt == div);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt <= '0;
        end else if (clr || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/pwm_core.sv
// ---------------------------------------------------------------------------
// pwm_core
//   PWM generator behind the register interface. Period, duty, prescale and
//   polarity are captured into shadow registers on start and on every counter
//   wrap, so a CTRL write never produces a partial or glitched period.
//
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   ctrl         in   live CTRL word
//   status       out  STATUS word (to register interface status_in)
//   pwm_out      out  registered PWM pin
//   period_tick  out  one-clock pulse after every counter wrap while active
//
//   Handshake: none. ctrl is a level-held register value, synchronous to clk;
//   status is a continuously valid level, no valid/ready involved.
// ---------------------------------------------------------------------------
module pwm_core
    import pwm_core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] ctrl,
    output logic [DATA_WIDTH-1:0] status,
    output logic                  pwm_out,
    output logic                  period_tick
);

    localparam int PERIOD_LSB = period_lsb(CNT_WIDTH);

    // Live CTRL fields
    logic                 ctrl_en;
    logic                 ctrl_pol;
    logic [PRESC_W-1:0]   ctrl_presc;
    logic [CNT_WIDTH-1:0] ctrl_duty;
    logic [CNT_WIDTH-1:0] ctrl_period;

    assign ctrl_en     = ctrl[EN_BIT];
    assign ctrl_pol    = ctrl[POL_BIT];
    assign ctrl_presc  = ctrl[PRESC_LSB +: PRESC_W];
    assign ctrl_duty   = ctrl[DUTY_LSB +: CNT_WIDTH];
    assign ctrl_period = ctrl[PERIOD_LSB +: CNT_WIDTH];

    logic unused_ctrl_bits;
    assign unused_ctrl_bits = ^ctrl[3:2];

    // State and shadows
    pwm_state_e           state;
    logic                 pol_sh;
    logic [PRESC_W-1:0]   presc_sh;
    logic [CNT_WIDTH-1:0] duty_sh;
    logic [CNT_WIDTH-1:0] period_sh;
    logic [CNT_WIDTH-1:0] cnt;

    logic active;
    logic tick;
    logic wrap;
    logic raw;
    logic load_sh;
    logic upd_pend;

    assign active = (state != ST_IDLE);
    assign wrap   = active && tick && (cnt == period_sh);
    assign raw    = (cnt < duty_sh);

    // Shadows load on start, and on any wrap that keeps the block running:
    // always in RUN (even if EN drops on the same edge), and in STOP only
    // when EN has come back. A STOP wrap with EN low ends in IDLE unloaded.
    assign load_sh = ((state == ST_IDLE) && ctrl_en) ||
                     (wrap && ((state == ST_RUN) || ctrl_en));

    assign upd_pend = active && ((ctrl_pol    != pol_sh)   ||
                                 (ctrl_presc  != presc_sh) ||
                                 (ctrl_duty   != duty_sh)  ||
                                 (ctrl_period != period_sh));

    // Prescaler held at 0 while idle so the first tick after start lands
    // exactly PRESC+1 clocks later; also restarted whenever shadows reload.
    pwm_prescaler u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!active || load_sh),
        .div     (presc_sh),
        .tick    (tick)
    );

    // FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (ctrl_en) state <= ST_RUN;
                ST_RUN:  if (!ctrl_en) state <= ST_STOP;
                ST_STOP: begin
                    if (ctrl_en)   state <= ST_RUN;
                    else if (wrap) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shadow registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pol_sh    <= 1'b0;
            presc_sh  <= '0;
            duty_sh   <= '0;
            period_sh <= '0;
        end else if (load_sh) begin
            pol_sh    <= ctrl_pol;
            presc_sh  <= ctrl_presc;
            duty_sh   <= ctrl_duty;
            period_sh <= ctrl_period;
        end
    end

    // Period counter and registered outputs. pwm_out is computed from the
    // current cnt, so it trails cnt by one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            period_tick <= wrap;
            pwm_out     <= active ? (raw ^ pol_sh) : ctrl_pol;
            if (!active || wrap) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // STATUS packing
    always_comb begin
        status                            = '0;
        status[ST_ACTIVE_BIT]             = active;
        status[ST_PWM_BIT]                = pwm_out;
        status[ST_UPD_BIT]                = upd_pend;
        status[ST_STOP_BIT]               = (state == ST_STOP);
        status[ST_CNT_LSB +: CNT_WIDTH]   = cnt;
    end

endmodule
